// File: rtl/mmu_pkg.sv
// Shared address map, DMA state encoding and echo-page handling for the
// banked MMU and its OAM DMA engine.
package mmu_pkg;

  localparam logic [15:0] ADDR_DMA      = 16'hFF46;
  localparam logic [15:0] ADDR_BIOS_OFF = 16'hFF50;
  localparam logic [15:0] HRAM_LO       = 16'hFF80;
  localparam logic [15:0] HRAM_HI       = 16'hFFFE;
  localparam logic [15:0] BIOS_END      = 16'h0100;

  // Regions selected by address bits [15:13] (8 KiB granularity).
  localparam logic [2:0] REGION_RAM_EN   = 3'd0;
  localparam logic [2:0] REGION_ROM_BANK = 3'd1;
  localparam logic [2:0] REGION_RAM_BANK = 3'd2;
  localparam logic [2:0] REGION_EXT_RAM  = 3'd5;

  localparam logic [1:0] DMA_IDLE  = 2'd0;
  localparam logic [1:0] DMA_XFER  = 2'd1;
  localparam logic [1:0] DMA_DRAIN = 2'd2;

  localparam logic [7:0] ECHO_PAGE_BASE = 8'hE0;
  localparam logic [7:0] ECHO_OFFSET    = 8'h20;

  // Pages in the echo area mirror work RAM 0x20 pages lower.
  function automatic logic [7:0] effectivePage(input logic [7:0] s);
    return (s >= ECHO_PAGE_BASE) ? s - ECHO_OFFSET : s;
  endfunction

endpackage

// File: rtl/mmu_banked_oam_dma.sv
// OAM DMA engine: streams DMA_LEN bytes from a source page into OAM,
// one address per cycle, writing each byte the cycle after its address.
module oam_dma
  import mmu_pkg::*;
#(
  parameter int DMA_LEN = 160
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iStart,
  input  logic [7:0]  iPage,
  output logic [15:0] oDmaReadAddr,
  input  logic [7:0]  iDmaReadData,
  output logic        oOamWe,
  output logic [7:0]  oOamAddr,
  output logic [7:0]  oOamData,
  output logic        oBusy
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  logic [1:0] stateQ, stateD;
  logic [7:0] idxQ, idxD;
  logic [7:0] pageQ, pageD;
  logic [7:0] prevIdxQ, prevIdxD;
  logic       pendQ, pendD;

  // A restart drops the in-flight write so the new transfer starts clean.
  always_comb begin
    stateD   = stateQ;
    idxD     = idxQ;
    pageD    = pageQ;
    prevIdxD = idxQ;
    pendD    = 1'b0;
    case (stateQ)
      DMA_XFER: begin
        pendD = 1'b1;
        if (idxQ == LAST_IDX) stateD = DMA_DRAIN;
        else                  idxD   = idxQ + 8'd1;
      end
      DMA_DRAIN: begin
        stateD = DMA_IDLE;
        idxD   = 8'd0;
      end
      default: stateD = DMA_IDLE;
    endcase
    if (iStart) begin
      stateD = DMA_XFER;
      idxD   = 8'd0;
      pageD  = iPage;
      pendD  = 1'b0;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      stateQ   <= DMA_IDLE;
      idxQ     <= 8'd0;
      pageQ    <= 8'd0;
      prevIdxQ <= 8'd0;
      pendQ    <= 1'b0;
    end else begin
      stateQ   <= stateD;
      idxQ     <= idxD;
      pageQ    <= pageD;
      prevIdxQ <= prevIdxD;
      pendQ    <= pendD;
    end
  end

  assign oDmaReadAddr = {pageQ, idxQ};
  assign oOamWe       = pendQ;
  assign oOamAddr     = prevIdxQ;
  assign oOamData     = iDmaReadData;
  assign oBusy        = (stateQ != DMA_IDLE);

endmodule

// File: rtl/mmu_banked.sv
// Banked cartridge MMU: boot-ROM overlay, ROM/RAM bank registers, address
// decode and CPU arbitration against the OAM DMA engine.
module mmu_banked
  import mmu_pkg::*;
#(
  parameter int ROM_BANK_BITS = 5,
  parameter int RAM_BANK_BITS = 2,
  parameter int DMA_LEN       = 160
) (
  input  logic                      iClock,
  input  logic                      iReset,
  input  logic [15:0]               iCpuAddr,
  input  logic                      iCpuWe,
  input  logic [7:0]                iCpuData,
  output logic [14+ROM_BANK_BITS-1:0] oRomAddr,
  output logic [13+RAM_BANK_BITS-1:0] oRamAddr,
  output logic                      oBiosSel,
  output logic                      oRamEnable,
  output logic [15:0]               oDmaReadAddr,
  input  logic [7:0]                iDmaReadData,
  output logic                      oOamWe,
  output logic [7:0]                oOamAddr,
  output logic [7:0]                oOamData,
  output logic                      oDmaBusy,
  output logic                      oCpuBlock,
  output logic [7:0]                oRegData
);

  localparam int RAM_W = (RAM_BANK_BITS > 0) ? RAM_BANK_BITS : 1;

  logic                     biosQ, biosD;
  logic [ROM_BANK_BITS-1:0] romBankQ, romBankD, romBankWr, romSel;
  logic [RAM_W-1:0]         ramBankQ, ramBankD, ramBankWr;
  logic                     ramEnQ, ramEnD;
  logic [7:0]               dmaRegQ, dmaRegD;
  logic                     hramHit, dmaHit, wrEn, dmaStart;

  assign hramHit   = (iCpuAddr >= HRAM_LO) && (iCpuAddr <= HRAM_HI);
  assign dmaHit    = (iCpuAddr == ADDR_DMA);
  assign oCpuBlock = oDmaBusy && !(hramHit || dmaHit);
  assign wrEn      = iCpuWe && !oCpuBlock;
  assign dmaStart  = wrEn && dmaHit;
  assign romBankWr = iCpuData[ROM_BANK_BITS-1:0];

  generate
    if (RAM_BANK_BITS > 0) begin : gRamBank
      assign ramBankWr = iCpuData[RAM_BANK_BITS-1:0];
      assign oRamAddr  = {ramBankQ, iCpuAddr[12:0]};
    end else begin : gNoRamBank
      assign ramBankWr = '0;
      assign oRamAddr  = iCpuAddr[12:0];
    end
  endgenerate

  // Bank 0 is never selectable in the switchable window; it reads as bank 1.
  always_comb begin
    biosD    = biosQ;
    romBankD = romBankQ;
    ramBankD = ramBankQ;
    ramEnD   = ramEnQ;
    dmaRegD  = dmaRegQ;
    if (wrEn) begin
      case (iCpuAddr[15:13])
        REGION_RAM_EN:   ramEnD   = (iCpuData[3:0] == 4'hA);
        REGION_ROM_BANK: romBankD = (romBankWr == '0) ? ROM_BANK_BITS'(1) : romBankWr;
        REGION_RAM_BANK: if (RAM_BANK_BITS > 0) ramBankD = ramBankWr;
        default: ;
      endcase
      if (iCpuAddr == ADDR_BIOS_OFF && iCpuData != 8'h00) biosD = 1'b0;
      if (dmaHit) dmaRegD = iCpuData;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      biosQ    <= 1'b1;
      romBankQ <= ROM_BANK_BITS'(1);
      ramBankQ <= '0;
      ramEnQ   <= 1'b0;
      dmaRegQ  <= 8'h00;
    end else begin
      biosQ    <= biosD;
      romBankQ <= romBankD;
      ramBankQ <= ramBankD;
      ramEnQ   <= ramEnD;
      dmaRegQ  <= dmaRegD;
    end
  end

  assign romSel     = (iCpuAddr[15:14] == 2'b00) ? '0 : romBankQ;
  assign oRomAddr   = {romSel, iCpuAddr[13:0]};
  assign oRamEnable = ramEnQ && (iCpuAddr[15:13] == REGION_EXT_RAM);
  assign oBiosSel   = biosQ && (iCpuAddr < BIOS_END);

  always_comb begin
    oRegData = 8'h00;
    if (iCpuAddr == ADDR_DMA)      oRegData = dmaRegQ;
    if (iCpuAddr == ADDR_BIOS_OFF) oRegData = 8'hFF;
  end

  oam_dma #(.DMA_LEN(DMA_LEN)) uDma (
    .iClock       (iClock),
    .iReset       (iReset),
    .iStart       (dmaStart),
    .iPage        (effectivePage(iCpuData)),
    .oDmaReadAddr (oDmaReadAddr),
    .iDmaReadData (iDmaReadData),
    .oOamWe       (oOamWe),
    .oOamAddr     (oOamAddr),
    .oOamData     (oOamData),
    .oBusy        (oDmaBusy)
  );

endmodule

// File: tb/tb_mmu_banked.sv
// Bench for mmu_banked: directed scenarios plus randomized register traffic
// and DMA transfers, checked against an arithmetic model of the MMU.
module tb_mmu_banked;

  localparam int ROM_BANK_BITS = 5;
  localparam int RAM_BANK_BITS = 2;
  localparam int DMA_LEN       = 160;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic [15:0] iCpuAddr = 16'h0000;
  logic        iCpuWe = 1'b0;
  logic [7:0]  iCpuData = 8'h00;
  logic [7:0]  iDmaReadData = 8'h00;
  logic [14+ROM_BANK_BITS-1:0] oRomAddr;
  logic [13+RAM_BANK_BITS-1:0] oRamAddr;
  logic        oBiosSel, oRamEnable, oOamWe, oDmaBusy, oCpuBlock;
  logic [15:0] oDmaReadAddr;
  logic [7:0]  oOamAddr, oOamData, oRegData;

  int vectors = 0;
  int miscompares = 0;

  int mBios, mRom, mRamBank, mRamEn, mFf46;

  logic [7:0] srcKey = 8'h00;
  logic [7:0] oam [256];
  logic [7:0] oamLog [$];
  int         busyCycles = 0;

  mmu_banked #(
    .ROM_BANK_BITS(ROM_BANK_BITS),
    .RAM_BANK_BITS(RAM_BANK_BITS),
    .DMA_LEN(DMA_LEN)
  ) dut (
    .iClock(iClock), .iReset(iReset),
    .iCpuAddr(iCpuAddr), .iCpuWe(iCpuWe), .iCpuData(iCpuData),
    .oRomAddr(oRomAddr), .oRamAddr(oRamAddr),
    .oBiosSel(oBiosSel), .oRamEnable(oRamEnable),
    .oDmaReadAddr(oDmaReadAddr), .iDmaReadData(iDmaReadData),
    .oOamWe(oOamWe), .oOamAddr(oOamAddr), .oOamData(oOamData),
    .oDmaBusy(oDmaBusy), .oCpuBlock(oCpuBlock), .oRegData(oRegData)
  );

  always #5 iClock = ~iClock;

  // Source memory: returns (low address byte XOR key) one cycle after the address.
  always @(posedge iClock) iDmaReadData <= oDmaReadAddr[7:0] ^ srcKey;

  always @(negedge iClock) begin
    if (oOamWe) begin
      oam[oOamAddr] = oOamData;
      oamLog.push_back(oOamAddr);
    end
    if (oDmaBusy) busyCycles++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mBios = 1; mRom = 1; mRamBank = 0; mRamEn = 0; mFf46 = 0;
  endtask

  task automatic modelWrite(input int a, input int d);
    if (a < 'h2000) mRamEn = ((d % 16) == 10) ? 1 : 0;
    else if (a < 'h4000) begin
      mRom = d % (1 << ROM_BANK_BITS);
      if (mRom == 0) mRom = 1;
    end
    else if (a < 'h6000) mRamBank = d % (1 << RAM_BANK_BITS);
    else if (a == 'hFF46) mFf46 = d;
    else if (a == 'hFF50 && d != 0) mBios = 0;
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d);
    iCpuAddr = a; iCpuData = d; iCpuWe = 1'b1;
    @(posedge iClock); #1;
    iCpuWe = 1'b0;
  endtask

  task automatic writeModeled(input logic [15:0] a, input logic [7:0] d);
    applyStimulus(a, d);
    modelWrite(int'(a), int'(d));
  endtask

  task automatic checkAccess(input logic [15:0] a);
    int ai, expRom, expRam, expRamEn, expBios, expReg;
    ai = int'(a);
    iCpuWe = 1'b0; iCpuAddr = a; #1;
    expRom   = (ai < 'h4000) ? ai : mRom * 'h4000 + ai % 'h4000;
    expRam   = mRamBank * 'h2000 + ai % 'h2000;
    expRamEn = (mRamEn != 0 && ai >= 'hA000 && ai < 'hC000) ? 1 : 0;
    expBios  = (mBios != 0 && ai < 'h100) ? 1 : 0;
    expReg   = (ai == 'hFF46) ? mFf46 : (ai == 'hFF50) ? 'hFF : 0;
    if (ai < 'h8000) checkOutput("romAddr", 32'(oRomAddr), expRom);
    checkOutput("ramAddr", 32'(oRamAddr), expRam);
    checkOutput("ramEnable", 32'(oRamEnable), expRamEn);
    checkOutput("biosSel", 32'(oBiosSel), expBios);
    checkOutput("regData", 32'(oRegData), expReg);
  endtask

  task automatic waitIdle(input string tag);
    for (int c = 0; c < 600; c++) begin
      if (!oDmaBusy) break;
      @(posedge iClock); #1;
    end
    checkOutput(tag, 32'(oDmaBusy), 0);
  endtask

  task automatic checkTransfer(input string tag, input int key);
    checkOutput({tag, "_busy"}, busyCycles, DMA_LEN + 1);
    checkOutput({tag, "_writes"}, oamLog.size(), DMA_LEN);
    if (oamLog.size() > 0) checkOutput({tag, "_first"}, 32'(oamLog[0]), 0);
    for (int k = 0; k < DMA_LEN; k++)
      checkOutput({tag, "_oam"}, 32'(oam[k]), (k ^ key) % 256);
  endtask

  task automatic startDma(input logic [7:0] page);
    writeModeled(16'hFF46, page);
    oamLog.delete();
    busyCycles = 0;
  endtask

  initial begin
    int page, expPage, key, r, d;
    modelReset();
    repeat (2) @(posedge iClock);
    #1 iReset = 1'b0;

    checkAccess(16'h0050);
    checkAccess(16'hFF46);
    checkOutput("rst_oamWe", 32'(oOamWe), 0);
    checkOutput("rst_busy", 32'(oDmaBusy), 0);
    checkOutput("rst_block", 32'(oCpuBlock), 0);
    checkAccess(16'h4000);

    writeModeled(16'hFF50, 8'h01);
    checkAccess(16'h0050);
    checkOutput("bios_off", 32'(oBiosSel), 0);
    writeModeled(16'hFF50, 8'h00);
    checkAccess(16'h0050);

    writeModeled(16'h2000, 8'h00);
    checkAccess(16'h4123);
    checkOutput("rom_bank0", 32'(oRomAddr), 32'h04123);
    writeModeled(16'h2000, 8'h1F);
    checkAccess(16'h4123);
    checkOutput("rom_bank1f", 32'(oRomAddr), 32'h7C123);

    writeModeled(16'h0000, 8'h0A);
    writeModeled(16'h4000, 8'h03);
    checkAccess(16'hA010);
    checkOutput("ram_addr", 32'(oRamAddr), 32'h6010);
    checkOutput("ram_en", 32'(oRamEnable), 1);
    writeModeled(16'h0000, 8'h00);
    checkAccess(16'hA010);

    // Reset asserted together with a bank write: the write must be lost.
    iReset = 1'b1;
    applyStimulus(16'h2000, 8'h07);
    iReset = 1'b0;
    modelReset();
    checkAccess(16'h4000);
    checkAccess(16'h0010);

    srcKey = 8'h00;
    startDma(8'hC1);
    checkOutput("dma_src0", 32'(oDmaReadAddr), 32'hC100);
    waitIdle("dma_c1_done");
    checkTransfer("dma_c1", 0);

    startDma(8'hE1);
    checkOutput("dma_echo", 32'(oDmaReadAddr), 32'hC100);
    checkAccess(16'hFF46);
    waitIdle("dma_e1_done");
    checkTransfer("dma_e1", 0);

    startDma(8'hC1);
    iCpuAddr = 16'h2000; iCpuData = 8'h05; iCpuWe = 1'b1; #1;
    checkOutput("block_rom", 32'(oCpuBlock), 1);
    @(posedge iClock); #1;
    iCpuWe = 1'b0; iCpuAddr = 16'hFF80; #1;
    checkOutput("block_hram", 32'(oCpuBlock), 0);
    iCpuAddr = 16'hFF46; #1;
    checkOutput("block_ff46", 32'(oCpuBlock), 0);
    waitIdle("dma_block_done");
    checkAccess(16'h4123);

    startDma(8'hC1);
    repeat (50) begin @(posedge iClock); #1; end
    checkOutput("restart_i50", 32'(oDmaReadAddr), 32'hC132);
    srcKey = 8'h5A;
    startDma(8'hC2);
    checkOutput("restart_src", 32'(oDmaReadAddr), 32'hC200);
    waitIdle("restart_done");
    checkTransfer("restart", 'h5A);

    srcKey = 8'h00;
    startDma(8'hC1);
    repeat (80) begin @(posedge iClock); #1; end
    checkOutput("abort_i80", 32'(oDmaReadAddr), 32'hC150);
    iReset = 1'b1;
    @(posedge iClock); #1;
    iReset = 1'b0;
    modelReset();
    checkOutput("abort_oamWe", 32'(oOamWe), 0);
    checkOutput("abort_busy", 32'(oDmaBusy), 0);
    checkAccess(16'hFF46);

    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 3));
      d = int'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) d = (d & 'hF0) | 'h0A;
      case (r)
        0: writeModeled(16'($urandom_range(16'h0000, 16'h1FFF)), 8'(d));
        1: writeModeled(16'($urandom_range(16'h2000, 16'h3FFF)), 8'(d));
        2: writeModeled(16'($urandom_range(16'h4000, 16'h5FFF)), 8'(d));
        default: writeModeled(16'hFF50, ($urandom_range(0, 3) == 0) ? 8'(d) : 8'h00);
      endcase
      case ($urandom_range(0, 4))
        0: checkAccess(16'($urandom_range(16'h0000, 16'h01FF)));
        1: checkAccess(16'($urandom_range(16'h4000, 16'h7FFF)));
        2: checkAccess(16'($urandom_range(16'hA000, 16'hBFFF)));
        3: checkAccess(($urandom_range(0, 1) == 1) ? 16'hFF46 : 16'hFF50);
        default: checkAccess(16'($urandom_range(0, 16'hFFFF)));
      endcase
    end

    for (int n = 0; n < 3; n++) begin
      page = int'($urandom_range(0, 255));
      key = int'($urandom_range(1, 255));
      expPage = (page >= 'hE0) ? page - 'h20 : page;
      srcKey = 8'(key);
      startDma(8'(page));
      checkOutput("rnd_src", 32'(oDmaReadAddr), expPage * 256);
      waitIdle("rnd_done");
      checkTransfer("rnd", key);
      checkAccess(16'hFF46);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
